// File: rtl/descrambler_if.sv
// Serial bit-stream interface for the descrambler.
// i_bit is the scrambled bit into the block; o_bit is the descrambled bit out of it.
interface descrambler_if;
  logic i_bit;
  logic o_bit;

  modport master (
    output i_bit,
    input  o_bit
  );

  modport slave (
    input  i_bit,
    output o_bit
  );
endinterface

// File: rtl/descrambler.sv
// Additive 802.11a descrambler (x^7 + x^4 + 1).
// The LFSR runs free from SEED. Received data never enters the state.
module descrambler #(
  parameter logic [6:0]  SEED  = 7'b1111111,
  parameter int unsigned TAP_A = 6,
  parameter int unsigned TAP_B = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  descrambler_if.slave  io_bus
);

  logic [6:0] r_lfsr;
  logic       w_pn;

  assign w_pn = r_lfsr[TAP_A] ^ r_lfsr[TAP_B];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[5:0], w_pn};
    end
  end

  // Zero-latency path: the output follows i_bit within the same cycle.
  assign io_bus.o_bit = io_bus.i_bit ^ w_pn;

endmodule

// File: tb/tb_descrambler.sv
// Directed bench for descrambler: keystream cancel, keystream regen, error isolation,
// async mid-stream reset, data recovery and hold-in-reset.
module tb_descrambler;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  // Default-seed keystream, bit 1 is the MSB.
  logic [126:0] ks;
  logic [31:0]  data;

  descrambler_if bus ();

  descrambler dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic ks_bit(input int k);
    return ks[127 - k];
  endfunction

  // Reset over two falling edges; ends at a falling edge with reset released.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one bit, check the combinational output, then pass one rising edge.
  task automatic step(input logic b, input logic exp, input string tag);
    bus.i_bit = b;
    #1;
    check_eq(tag, 32'(bus.o_bit), 32'(exp));
    @(negedge clk);
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    ks        = 127'b0000111011110010110010010000001000100110001011101011011000001100110101001110011110110100001010101111101001010001101110001111111;
    data      = 32'hB2B2_B2B2;
    rst       = 1'b1;
    bus.i_bit = 1'b0;
    #1;
    check_eq("reset_lfsr", 32'(dut.r_lfsr), 32'h7F);
    @(negedge clk);

    // 1: feeding the keystream itself descrambles to all zeros.
    do_reset();
    for (int k = 1; k <= 127; k++) step(ks_bit(k), 1'b0, "ks_cancel");

    // 2: zero input reproduces the keystream; bit 128 wraps to bit 1.
    do_reset();
    for (int k = 1; k <= 127; k++) step(1'b0, ks_bit(k), "ks_regen");
    step(1'b0, 1'b0, "ks_period");

    // 3: a single flipped bit affects only its own position.
    do_reset();
    for (int k = 1; k <= 127; k++) begin
      logic b;
      b = ks_bit(k) ^ (k == 20);
      step(b, (k == 20), "err_isolate");
    end

    // 4: asynchronous reset between edges reloads the seed immediately.
    do_reset();
    for (int k = 1; k <= 50; k++) step(ks_bit(k), 1'b0, "pre_async");
    #2;
    rst = 1'b1;
    bus.i_bit = 1'b1;
    #1;
    check_eq("async_lfsr", 32'(dut.r_lfsr), 32'h7F);
    check_eq("async_out", 32'(bus.o_bit), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 127; k++) step(ks_bit(k), 1'b0, "post_async");

    // 5: scrambled data is recovered.
    do_reset();
    for (int k = 1; k <= 32; k++) step(data[32 - k] ^ ks_bit(k), data[32 - k], "data_rec");

    // 6: held in reset the state stays at seed and output equals input.
    rst = 1'b1;
    bus.i_bit = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check_eq("hold_out", 32'(bus.o_bit), 32'h1);
      check_eq("hold_lfsr", 32'(dut.r_lfsr), 32'h7F);
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/descrambler.md
Name: descrambler

Overview:
- 802.11a receive-path descrambler placed after the deinterleaver/decoder.
- Removes the frame-synchronous scrambling applied at the transmitter by XOR-ing each received bit with the generator x^7 + x^4 + 1 sequence.
- This is an additive (frame-synchronous) descrambler, not self-synchronizing. The LFSR runs free from its reset seed and the received data never feeds back into it.
- Processes one bit per clock cycle.

Parameters:
- SEED, 7'b1111111, LFSR value loaded on reset; bit 6 is the oldest tap x^7, bit 0 is the newest.
- TAP_A, 6, index of the x^7 tap in the state register.
- TAP_B, 3, index of the x^4 tap in the state register.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high; loads SEED into the LFSR.
- Input  input  1  scrambled serial bit, one per cycle.
- Output  output  1  descrambled serial bit.

Behaviour:
- State: a 7-bit register `lfsr[6:0]`.
- Keystream bit: `pn = lfsr[TAP_A] ^ lfsr[TAP_B]`. It is combinational from the current state.
- Output: `Output = Input ^ pn`.
  - Purely combinational from Input and the current state; zero cycles of latency.
  - Within a cycle, Output follows changes on Input immediately.
- Update on each rising Clock edge while Reset is low: `lfsr <= {lfsr[5:0], pn}`.
  - Shift toward the MSB.
  - The new bit enters at bit 0.
- Reset asserted, at any time including mid-stream:
  - `lfsr` takes SEED immediately, without waiting for a clock edge.
  - `lfsr` stays at SEED while Reset is high.
  - Output during reset equals `Input ^ (SEED[6] ^ SEED[3])`, which is `Input ^ 0` for the default seed.
- After Reset deasserts:
  - The first bit presented is XOR-ed with keystream bit 1.
  - Each following rising edge advances to the next keystream bit.
- Keystream from the default seed: `00001110 11110010 11001001 00000010 00100110 00101110 10110110 00001100 ...`
  - Period is 127 bits (maximal length).
  - The sequence then repeats from bit 1.
- Never-reachable state: `lfsr` must never become all zeros. This is guaranteed only for a non-zero SEED; SEED = 0 is illegal.
- Input does not affect `lfsr`. Errors on Input must not propagate beyond the bit in which they occur.
- No enable and no handshake: every rising edge consumes one bit.
- No X-propagation: the register must not depend on Input.

Test Plan:
1. Reset pulse, then feed the 127-bit default-seed keystream (`0000111011110010110010010000001000100110001011101011011000001100110101001110011110110100001010101111101001010001101110001111111`) one bit per cycle -> Output = 0 on all 127 bits.
2. Reset, then feed all-zero Input for 127 cycles -> Output reproduces the keystream above bit for bit. Cycle 128 output equals cycle 1 output (0), confirming the 127-bit period.
3. Reset, then feed the keystream with bit 20 inverted -> Output = 1 only at bit 20 and 0 elsewhere, confirming no error propagation.
4. Reset, feed 50 keystream bits, then assert Reset asynchronously between clock edges -> `lfsr` = 7'b1111111 immediately. Restarting the keystream from bit 1 gives Output = 0 for all bits.
5. Reset, feed the XOR of the keystream with data `10110010...` -> Output = `10110010...`, confirming data recovery.
6. Hold Reset high for 5 clock edges with Input = 1 -> Output stays 1 and `lfsr` stays 7'b1111111.
